// File: rtl/soundgen_pkg.sv
// Shared defaults and helpers for the soundgen voice mixers.
// Saturation is done on a 64-bit signed carrier so one function serves every width.
package soundgen_pkg;

    localparam int unsigned NCHAN_DEF    = 2;
    localparam int unsigned SW_DEF       = 10;
    localparam int unsigned MIDPOINT_DEF = 512;
    localparam int unsigned GW_DEF       = 18;
    localparam int unsigned OW_DEF       = 18;
    localparam int unsigned GSHIFT_DEF   = 11;
    localparam int unsigned GUARD_DEF    = 6;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned chan_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned CW_DEF = chan_width(NCHAN_DEF);

    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic in_range(input logic signed [63:0] v, input int unsigned w);
        return sat(v, w) == v;
    endfunction

endpackage

// File: rtl/soundgen_mac.sv
// Two-stage gain pipeline: centres the sample, forms volume*velocity, then scales to a
// sign-extended contribution. Channel, valid and the frame tick travel alongside.
module soundgen_mac
    import soundgen_pkg::*;
#(
    parameter int unsigned NCHAN    = NCHAN_DEF,
    parameter int unsigned SW       = SW_DEF,
    parameter int unsigned MIDPOINT = MIDPOINT_DEF,
    parameter int unsigned GW       = GW_DEF,
    parameter int unsigned GSHIFT   = GSHIFT_DEF,
    parameter int unsigned AW       = OW_DEF + GUARD_DEF,
    parameter int unsigned CW       = chan_width(NCHAN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW-1:0]        sample,
    input  logic                 sample_valid,
    input  logic [CW-1:0]        sample_chan,
    input  logic [GW-1:0]        volume_adsr,
    input  logic [GW-1:0]        velocity,
    input  logic                 tick,
    output logic signed [AW-1:0] contrib,
    output logic                 contrib_valid,
    output logic [CW-1:0]        contrib_chan,
    output logic                 contrib_tick
);

    localparam int unsigned PW = SW + GW + 2;

    logic signed [SW:0]   centred_d, centred_q;
    logic [2*GW-1:0]      gain_full;
    logic [GW-1:0]        gain_d, gain_q;
    logic                 valid1_d, valid1_q;
    logic [CW-1:0]        chan1_q;
    logic                 tick1_q;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic signed [AW-1:0] contrib_d;

    // S1: offset-binary to signed, and the combined gain as a GW-bit fraction.
    always_comb begin
        centred_d = $signed({1'b0, sample}) - $signed((SW + 1)'(MIDPOINT));
        gain_full = (2 * GW)'(volume_adsr) * (2 * GW)'(velocity);
        gain_d    = gain_full[2*GW-1:GW];
        valid1_d  = sample_valid && (32'(sample_chan) < NCHAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            centred_q <= '0;
            gain_q    <= '0;
            valid1_q  <= 1'b0;
            chan1_q   <= '0;
            tick1_q   <= 1'b0;
        end else begin
            centred_q <= centred_d;
            gain_q    <= gain_d;
            valid1_q  <= valid1_d;
            chan1_q   <= sample_chan;
            tick1_q   <= tick;
        end
    end

    // S2: signed product, then arithmetic shift and sign-extension into the accumulator width.
    always_comb begin
        prod      = PW'(centred_q) * PW'($signed({1'b0, gain_q}));
        prod_sh   = prod >>> GSHIFT;
        contrib_d = AW'(prod_sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            contrib       <= '0;
            contrib_valid <= 1'b0;
            contrib_chan  <= '0;
            contrib_tick  <= 1'b0;
        end else begin
            contrib       <= contrib_d;
            contrib_valid <= valid1_q;
            contrib_chan  <= chan1_q;
            contrib_tick  <= tick1_q;
        end
    end

endmodule

// File: rtl/soundgen_mixn.sv
// N-channel voice mixer: per-channel saturating accumulators fed by soundgen_mac, published
// as saturated signed samples when the delayed frame tick reaches the accumulator stage.
module soundgen_mixn
    import soundgen_pkg::*;
#(
    parameter int unsigned NCHAN    = NCHAN_DEF,
    parameter int unsigned SW       = SW_DEF,
    parameter int unsigned MIDPOINT = MIDPOINT_DEF,
    parameter int unsigned GW       = GW_DEF,
    parameter int unsigned OW       = OW_DEF,
    parameter int unsigned GSHIFT   = GSHIFT_DEF,
    parameter int unsigned GUARD    = GUARD_DEF,
    parameter int unsigned CW       = chan_width(NCHAN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW-1:0]         sample,
    input  logic                  sample_valid,
    input  logic [CW-1:0]         sample_chan,
    input  logic [GW-1:0]         volume_adsr,
    input  logic [GW-1:0]         velocity,
    input  logic                  tick48k,
    output logic [NCHAN*OW-1:0]   sound,
    output logic                  sound_valid,
    output logic [NCHAN-1:0]      clip
);

    localparam int unsigned AW = OW + GUARD;

    logic signed [AW-1:0] mac_contrib;
    logic                 mac_valid;
    logic [CW-1:0]        mac_chan;
    logic                 mac_tick;

    logic signed [AW-1:0] acc_d [NCHAN];
    logic signed [AW-1:0] acc_q [NCHAN];
    logic [NCHAN*OW-1:0]  sound_d;
    logic [NCHAN-1:0]     clip_d;
    logic signed [AW:0]   sum;
    logic                 hit;

    soundgen_mac #(
        .NCHAN    (NCHAN),
        .SW       (SW),
        .MIDPOINT (MIDPOINT),
        .GW       (GW),
        .GSHIFT   (GSHIFT),
        .AW       (AW),
        .CW       (CW)
    ) u_mac (
        .clk           (clk),
        .rst           (rst),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .sample_chan   (sample_chan),
        .volume_adsr   (volume_adsr),
        .velocity      (velocity),
        .tick          (tick48k),
        .contrib       (mac_contrib),
        .contrib_valid (mac_valid),
        .contrib_chan  (mac_chan),
        .contrib_tick  (mac_tick)
    );

    // S3: a sample arriving with the tick opens the next frame instead of closing this one.
    always_comb begin
        sound_d = sound;
        clip_d  = clip;
        sum     = '0;
        hit     = 1'b0;
        for (int c = 0; c < NCHAN; c++) begin
            acc_d[c] = acc_q[c];
            hit      = mac_valid && (32'(mac_chan) == c);
            sum      = (AW + 1)'(acc_q[c]) + (AW + 1)'(mac_contrib);
            if (mac_tick) begin
                sound_d[c*OW +: OW] = OW'(sat(64'(acc_q[c]), OW));
                clip_d[c]           = !in_range(64'(acc_q[c]), OW);
                acc_d[c]            = hit ? mac_contrib : '0;
            end else if (hit) begin
                acc_d[c] = AW'(sat(64'(sum), AW));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '{default: '0};
            sound       <= '0;
            clip        <= '0;
            sound_valid <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sound       <= sound_d;
            clip        <= clip_d;
            sound_valid <= mac_tick;
        end
    end

endmodule

// File: tb/tb_soundgen_mixn.sv
// Directed bench for soundgen_mixn: expected frames are queued when the tick is driven and
// checked against the published sound; sound/clip must hold between publications.
module tb_soundgen_mixn;

    // Three channels so a 2-bit sample_chan can carry an out-of-range index (3).
    localparam int unsigned NCHAN = 3;
    localparam int unsigned OW    = 18;
    localparam logic [17:0] FULL  = 18'h3FFFF;

    logic                  clk;
    logic                  rst;
    logic [9:0]            sample;
    logic                  sample_valid;
    logic [1:0]            sample_chan;
    logic [17:0]           volume_adsr;
    logic [17:0]           velocity;
    logic                  tick48k;
    logic [NCHAN*OW-1:0]   sound;
    logic                  sound_valid;
    logic [NCHAN-1:0]      clip;

    typedef struct {
        logic [NCHAN*OW-1:0] snd;
        logic [NCHAN-1:0]    clp;
        int                  due;
    } exp_t;

    exp_t                sb[$];
    exp_t                e;
    logic [NCHAN*OW-1:0] hold_snd;
    logic [NCHAN-1:0]    hold_clp;
    int                  cyc;
    int                  checks;
    int                  failures;

    soundgen_mixn #(
        .NCHAN (NCHAN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .volume_adsr  (volume_adsr),
        .velocity     (velocity),
        .tick48k      (tick48k),
        .sound        (sound),
        .sound_valid  (sound_valid),
        .clip         (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [NCHAN*OW-1:0] pk(input int a, input int b, input int c);
        logic [OW-1:0] x;
        logic [OW-1:0] y;
        logic [OW-1:0] z;
        x = OW'(a);
        y = OW'(b);
        z = OW'(c);
        return {z, y, x};
    endfunction

    // One clock: inputs already driven are sampled at the edge, outputs checked 1 time unit later.
    task automatic step();
        logic rst_at_edge;
        @(posedge clk);
        cyc++;
        rst_at_edge = rst;
        #1;
        if (rst_at_edge) begin
            hold_snd = '0;
            hold_clp = '0;
        end
        if (sound_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(sound_valid), 64'(1'b0));
            end else begin
                e = sb.pop_front();
                chk("valid_latency", 64'(cyc), 64'(e.due));
                chk("frame_sound", 64'(sound), 64'(e.snd));
                chk("frame_clip", 64'(clip), 64'(e.clp));
                hold_snd = e.snd;
                hold_clp = e.clp;
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            chk("missing_valid", 64'(sound_valid), 64'(1'b1));
            void'(sb.pop_front());
        end
        chk("hold_sound", 64'(sound), 64'(hold_snd));
        chk("hold_clip", 64'(clip), 64'(hold_clp));
    endtask

    task automatic push(input logic [NCHAN*OW-1:0] snd, input logic [NCHAN-1:0] clp);
        exp_t x;
        x.snd = snd;
        x.clp = clp;
        x.due = cyc + 3;  // edge cyc+1 samples the tick; sound updates two edges later
        sb.push_back(x);
    endtask

    task automatic drive(input logic [9:0] s, input logic [1:0] ch, input logic [17:0] vo,
                         input logic [17:0] ve, input logic v, input logic t);
        sample       = s;
        sample_chan  = ch;
        volume_adsr  = vo;
        velocity     = ve;
        sample_valid = v;
        tick48k      = t;
        step();
        sample_valid = 1'b0;
        tick48k      = 1'b0;
    endtask

    task automatic voice(input logic [9:0] s, input logic [1:0] ch);
        drive(s, ch, FULL, FULL, 1'b1, 1'b0);
    endtask

    task automatic tick_only();
        drive(10'd512, 2'd0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    initial begin
        cyc          = 0;
        checks       = 0;
        failures     = 0;
        hold_snd     = '0;
        hold_clp     = '0;
        rst          = 1'b1;
        sample       = '0;
        sample_valid = 1'b0;
        sample_chan  = '0;
        volume_adsr  = '0;
        velocity     = '0;
        tick48k      = 1'b0;

        // 1: reset state, then an empty frame
        idle(5);
        chk("reset_sound", 64'(sound), 64'(pk(0, 0, 0)));
        chk("reset_clip", 64'(clip), 64'(3'b000));
        chk("reset_valid", 64'(sound_valid), 64'(1'b0));
        rst = 1'b0;
        idle(1);
        push(pk(0, 0, 0), 3'b000);
        tick_only();
        idle(3);

        // 2: full-scale positive voice on ch0
        voice(10'd1023, 2'd0);
        push(pk(65407, 0, 0), 3'b000);
        tick_only();
        idle(3);

        // 3: full-scale negative on ch1, silence with arbitrary gain on ch0
        voice(10'd0, 2'd1);
        drive(10'd512, 2'd0, 18'($urandom), 18'($urandom), 1'b1, 1'b0);
        push(pk(0, -65536, 0), 3'b000);
        tick_only();
        idle(3);

        // 4: positive and negative saturation, then an empty frame clears clip
        for (int i = 0; i < 4; i++) voice(10'd1023, 2'd0);
        for (int i = 0; i < 6; i++) voice(10'd0, 2'd1);
        push(pk(131071, -131072, 0), 3'b011);
        tick_only();
        idle(3);
        push(pk(0, 0, 0), 3'b000);
        tick_only();
        idle(3);

        // 5: out-of-range channel dropped; sample coincident with tick goes to next frame
        voice(10'd1023, 2'd3);
        push(pk(0, 0, 0), 3'b000);
        drive(10'd1023, 2'd0, FULL, FULL, 1'b1, 1'b1);
        idle(1);
        push(pk(65407, 0, 0), 3'b000);
        tick_only();
        idle(3);

        // back-to-back ticks: second frame publishes zero
        voice(10'd1023, 2'd2);
        push(pk(0, 0, 65407), 3'b000);
        tick_only();
        push(pk(0, 0, 0), 3'b000);
        tick_only();
        idle(3);

        // 6: reset mid-frame with a tick in flight; nothing may be published
        voice(10'd1023, 2'd2);
        push(pk(0, 0, 65407), 3'b000);
        tick_only();
        idle(3);
        for (int i = 0; i < 3; i++) voice(10'd1023, 2'd0);
        tick_only();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("valid_in_reset", 64'(sound_valid), 64'(1'b0));
        end
        rst = 1'b0;
        push(pk(0, 0, 0), 3'b000);
        tick_only();
        idle(6);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
